// File: rtl/can_crc_engine_if.sv
// Bit-stream side bundle of the CAN CRC engine: control strobes in, CRC status out.
interface can_crc_engine_if #(
    parameter int unsigned CRC_W = 15
);
    logic             start;
    logic             tx_mode;
    logic             bit_valid;
    logic             bit_in;
    logic             data_end;
    logic [CRC_W-1:0] crc_value;
    logic             crc_bit_out;
    logic             busy;
    logic             done;
    logic             crc_ok;

    modport master (
        output start, tx_mode, bit_valid, bit_in, data_end,
        input  crc_value, crc_bit_out, busy, done, crc_ok
    );

    modport slave (
        input  start, tx_mode, bit_valid, bit_in, data_end,
        output crc_value, crc_bit_out, busy, done, crc_ok
    );
endinterface

// File: rtl/can_crc_engine.sv
// Serial CAN CRC generator/checker: accumulates over destuffed frame bits, then
// either shifts the CRC out (transmitter) or checks the received field by residue.
module can_crc_engine #(
    parameter int unsigned      CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = 15'h4599,
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input logic              clk,
    input logic              reset,
    can_crc_engine_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(CRC_W + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        CRC_FIELD = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_q, tx_d;
    logic [CRC_W-1:0] value_q, value_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;

    // One serial step of the CRC division for input bit b.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic [CRC_W-1:0] s;
        s = c << 1;
        if (b ^ c[CRC_W-1]) s = s ^ POLY;
        return s;
    endfunction

    // Next-state and registered-output logic; start overrides everything.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        value_d = value_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ok_d    = ok_q;

        if (bus.start) begin
            state_d = ACCUM;
            crc_d   = INIT;
            cnt_d   = '0;
            tx_d    = bus.tx_mode;
            busy_d  = 1'b1;
            ok_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ACCUM: begin
                    if (bus.bit_valid) crc_d = crc_step(crc_q, bus.bit_in);
                    // A bit arriving with data_end is folded in before the snapshot.
                    if (bus.data_end) begin
                        value_d = crc_d;
                        cnt_d   = '0;
                        state_d = CRC_FIELD;
                    end
                end
                CRC_FIELD: begin
                    if (bus.bit_valid) begin
                        crc_d = tx_q ? (crc_q << 1) : crc_step(crc_q, bus.bit_in);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(CRC_W)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            ok_d    = tx_q | (crc_d == '0);
                        end
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            value_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            value_q <= value_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    // The transmitted bit comes straight off the register MSB so it is ready on field entry.
    assign bus.crc_bit_out = (state_q == CRC_FIELD) && tx_q && crc_q[CRC_W-1];
    assign bus.crc_value   = value_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.crc_ok      = ok_q;
endmodule

// File: tb/tb_can_crc_engine.sv
// Directed bench for can_crc_engine: classic CRC-15 instance plus a CAN FD CRC-17 instance.
module tb_can_crc_engine;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    can_crc_engine_if #(.CRC_W(15)) bus15 ();
    can_crc_engine_if #(.CRC_W(17)) bus17 ();

    can_crc_engine u_dut15 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus15.slave)
    );

    can_crc_engine #(
        .CRC_W (17),
        .POLY  (17'h1685B),
        .INIT  (17'h10000)
    ) u_dut17 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus17.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_start(input logic mode, input logic bv, input logic b);
        bus15.start     = 1'b1;
        bus15.tx_mode   = mode;
        bus15.bit_valid = bv;
        bus15.bit_in    = b;
        tick();
        bus15.start     = 1'b0;
        bus15.bit_valid = 1'b0;
        bus15.bit_in    = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic de);
        bus15.bit_valid = 1'b1;
        bus15.bit_in    = b;
        bus15.data_end  = de;
        tick();
        bus15.bit_valid = 1'b0;
        bus15.bit_in    = 1'b0;
        bus15.data_end  = 1'b0;
    endtask

    task automatic send_end();
        bus15.data_end = 1'b1;
        tick();
        bus15.data_end = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++; if (bus15.busy !== 1'b0) begin errors++; $display("FAIL reset_busy15: got %b want 0", bus15.busy); end
        checks++; if (bus15.done !== 1'b0) begin errors++; $display("FAIL reset_done15: got %b want 0", bus15.done); end
        checks++; if (bus15.crc_ok !== 1'b0) begin errors++; $display("FAIL reset_ok15: got %b want 0", bus15.crc_ok); end
        checks++; if (bus15.crc_value !== 15'h0) begin errors++; $display("FAIL reset_value15: got %h want 0", bus15.crc_value); end
        checks++; if (bus15.crc_bit_out !== 1'b0) begin errors++; $display("FAIL reset_bitout15: got %b want 0", bus15.crc_bit_out); end
        checks++; if (bus17.crc_value !== 17'h0) begin errors++; $display("FAIL reset_value17: got %h want 0", bus17.crc_value); end
        checks++; if (bus17.busy !== 1'b0) begin errors++; $display("FAIL reset_busy17: got %b want 0", bus17.busy); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_tx_shift();
        logic [14:0] exp_bits;
        exp_bits = 15'b100010110011001;
        send_start(1'b1, 1'b0, 1'b0);
        checks++; if (bus15.busy !== 1'b1) begin errors++; $display("FAIL tx_busy_start: got %b want 1", bus15.busy); end
        send_bit(1'b1, 1'b1);
        checks++; if (bus15.crc_value !== 15'h4599) begin errors++; $display("FAIL tx_value: got %h want 4599", bus15.crc_value); end
        for (int i = 0; i < 15; i++) begin
            checks++; if (bus15.crc_bit_out !== exp_bits[14-i]) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", i, bus15.crc_bit_out, exp_bits[14-i]); end
            checks++; if (bus15.done !== 1'b0) begin errors++; $display("FAIL tx_early_done%0d: got %b want 0", i, bus15.done); end
            send_bit(1'b1, 1'b0);
        end
        checks++; if (bus15.done !== 1'b1) begin errors++; $display("FAIL tx_done: got %b want 1", bus15.done); end
        checks++; if (bus15.busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end: got %b want 0", bus15.busy); end
        checks++; if (bus15.crc_ok !== 1'b1) begin errors++; $display("FAIL tx_ok: got %b want 1", bus15.crc_ok); end
        checks++; if (bus15.crc_bit_out !== 1'b0) begin errors++; $display("FAIL tx_bitout_done: got %b want 0", bus15.crc_bit_out); end
        tick();
        checks++; if (bus15.done !== 1'b0) begin errors++; $display("FAIL tx_done_pulse: got %b want 0", bus15.done); end
        checks++; if (bus15.crc_ok !== 1'b1) begin errors++; $display("FAIL tx_ok_hold: got %b want 1", bus15.crc_ok); end
        checks++; if (bus15.crc_value !== 15'h4599) begin errors++; $display("FAIL tx_value_hold: got %h want 4599", bus15.crc_value); end
    endtask

    // flip < 0 sends the correct CRC field; otherwise that field bit is inverted.
    task automatic test_rx_check(input int flip, input logic exp_ok);
        logic [14:0] field;
        field = 15'h4EAB;
        if (flip >= 0) field[flip] = ~field[flip];
        send_start(1'b0, 1'b0, 1'b0);
        checks++; if (bus15.crc_ok !== 1'b0) begin errors++; $display("FAIL rx_ok_cleared: got %b want 0", bus15.crc_ok); end
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_end();
        checks++; if (bus15.crc_value !== 15'h4EAB) begin errors++; $display("FAIL rx_value: got %h want 4eab", bus15.crc_value); end
        for (int i = 0; i < 15; i++) begin
            send_bit(field[14-i], 1'(i == 3));
        end
        checks++; if (bus15.done !== 1'b1) begin errors++; $display("FAIL rx_done: got %b want 1", bus15.done); end
        checks++; if (bus15.crc_ok !== exp_ok) begin errors++; $display("FAIL rx_ok flip=%0d: got %b want %b", flip, bus15.crc_ok, exp_ok); end
        checks++; if (bus15.crc_value !== 15'h4EAB) begin errors++; $display("FAIL rx_value_hold: got %h want 4eab", bus15.crc_value); end
        tick();
    endtask

    task automatic test_abort();
        logic [14:0] field;
        field = 15'h4EAB;
        send_start(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'(i % 2), 1'b0);
        send_start(1'b0, 1'b1, 1'b1);
        checks++; if (bus15.done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", bus15.done); end
        checks++; if (bus15.busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", bus15.busy); end
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_end();
        checks++; if (bus15.crc_value !== 15'h4EAB) begin errors++; $display("FAIL abort_value: got %h want 4eab", bus15.crc_value); end
        for (int i = 0; i < 15; i++) begin
            checks++; if (bus15.done !== 1'b0) begin errors++; $display("FAIL abort_early_done%0d: got %b want 0", i, bus15.done); end
            send_bit(field[14-i], 1'b0);
        end
        checks++; if (bus15.done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b want 1", bus15.done); end
        checks++; if (bus15.crc_ok !== 1'b1) begin errors++; $display("FAIL abort_ok: got %b want 1", bus15.crc_ok); end
        tick();
    endtask

    task automatic test_async_reset();
        send_start(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        checks++; if (bus15.crc_bit_out !== 1'b1) begin errors++; $display("FAIL ar_pre_bitout: got %b want 1", bus15.crc_bit_out); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus15.crc_value !== 15'h0) begin errors++; $display("FAIL ar_value: got %h want 0", bus15.crc_value); end
        checks++; if (bus15.crc_bit_out !== 1'b0) begin errors++; $display("FAIL ar_bitout: got %b want 0", bus15.crc_bit_out); end
        checks++; if (bus15.busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", bus15.busy); end
        checks++; if (bus15.done !== 1'b0) begin errors++; $display("FAIL ar_done: got %b want 0", bus15.done); end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b1);
        checks++; if (bus15.busy !== 1'b0) begin errors++; $display("FAIL ar_idle_busy: got %b want 0", bus15.busy); end
        checks++; if (bus15.done !== 1'b0) begin errors++; $display("FAIL ar_idle_done: got %b want 0", bus15.done); end
        checks++; if (bus15.crc_value !== 15'h0) begin errors++; $display("FAIL ar_idle_value: got %h want 0", bus15.crc_value); end
    endtask

    task automatic test_back_to_back();
        send_start(1'b0, 1'b0, 1'b0);
        send_end();
        checks++; if (bus15.crc_value !== 15'h0) begin errors++; $display("FAIL b2b_empty_value: got %h want 0", bus15.crc_value); end
        for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b0);
        checks++; if (bus15.done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", bus15.done); end
        checks++; if (bus15.crc_ok !== 1'b1) begin errors++; $display("FAIL b2b_ok1: got %b want 1", bus15.crc_ok); end
        send_start(1'b1, 1'b0, 1'b0);
        checks++; if (bus15.done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b want 0", bus15.done); end
        checks++; if (bus15.crc_ok !== 1'b0) begin errors++; $display("FAIL b2b_ok_clear: got %b want 0", bus15.crc_ok); end
        checks++; if (bus15.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", bus15.busy); end
        send_bit(1'b1, 1'b1);
        checks++; if (bus15.crc_value !== 15'h4599) begin errors++; $display("FAIL b2b_value2: got %h want 4599", bus15.crc_value); end
        for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b0);
        checks++; if (bus15.done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", bus15.done); end
        tick();
    endtask

    task automatic test_crc17();
        bus17.start   = 1'b1;
        bus17.tx_mode = 1'b1;
        tick();
        bus17.start    = 1'b0;
        bus17.data_end = 1'b1;
        tick();
        bus17.data_end = 1'b0;
        checks++; if (bus17.crc_value !== 17'h10000) begin errors++; $display("FAIL c17_value: got %h want 10000", bus17.crc_value); end
        for (int i = 0; i < 17; i++) begin
            checks++; if (bus17.crc_bit_out !== 1'(i == 0)) begin errors++; $display("FAIL c17_bit%0d: got %b want %b", i, bus17.crc_bit_out, (i == 0)); end
            checks++; if (bus17.done !== 1'b0) begin errors++; $display("FAIL c17_early_done%0d: got %b want 0", i, bus17.done); end
            bus17.bit_valid = 1'b1;
            tick();
            bus17.bit_valid = 1'b0;
        end
        checks++; if (bus17.done !== 1'b1) begin errors++; $display("FAIL c17_done: got %b want 1", bus17.done); end
        checks++; if (bus17.crc_ok !== 1'b1) begin errors++; $display("FAIL c17_ok: got %b want 1", bus17.crc_ok); end
        checks++; if (bus17.busy !== 1'b0) begin errors++; $display("FAIL c17_busy: got %b want 0", bus17.busy); end
        tick();
        checks++; if (bus17.done !== 1'b0) begin errors++; $display("FAIL c17_done_pulse: got %b want 0", bus17.done); end
    endtask

    initial begin
        bus15.start = 1'b0; bus15.tx_mode = 1'b0; bus15.bit_valid = 1'b0;
        bus15.bit_in = 1'b0; bus15.data_end = 1'b0;
        bus17.start = 1'b0; bus17.tx_mode = 1'b0; bus17.bit_valid = 1'b0;
        bus17.bit_in = 1'b0; bus17.data_end = 1'b0;
        test_reset();
        test_tx_shift();
        test_rx_check(-1, 1'b0 == 1'b0);
        test_rx_check(5, 1'b0);
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_crc17();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
